// File: rtl/dic_pkg.sv
// Shared types and constants for the digital clock command front end.
//   dic_state_t : load-sequencing FSM states
//   ASCII_* / KEY_*_DEF : byte codes for digits and default command keys
//   TENS_MAX / ONES_MAX : highest value accepted for a tens / ones digit
package dic_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_MT = 3'd1,
        LD_MO = 3'd2,
        LD_ST = 3'd3,
        LD_SO = 3'd4
    } dic_state_t;

    localparam logic [BYTE_W-1:0] ASCII_0       = 8'h30;
    localparam logic [BYTE_W-1:0] ASCII_9       = 8'h39;
    localparam logic [BYTE_W-1:0] KEY_LOAD_DEF  = 8'h6C;
    localparam logic [BYTE_W-1:0] KEY_RUN_DEF   = 8'h72;
    localparam logic [BYTE_W-1:0] KEY_STOP_DEF  = 8'h73;
    localparam logic [BYTE_W-1:0] KEY_NEXT_DEF  = 8'h6E;
    localparam logic [BYTE_W-1:0] KEY_ABORT_DEF = 8'h1B;

    localparam logic [DIGIT_W-1:0] TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] ONES_MAX = 4'd9;

    // Tens positions (minutes/seconds) only go to 5; ones positions go to 9.
    function automatic logic [DIGIT_W-1:0] digit_limit(input dic_state_t s);
        return ((s == LD_MT) || (s == LD_ST)) ? TENS_MAX : ONES_MAX;
    endfunction

endpackage

// File: rtl/dicmd_ctrl_if.sv
// Bus between the UART receiver / clock datapath and the command controller.
//   rx_data, rx_valid       : received byte and its one-cycle strobe
//   dicRun                  : clock run enable
//   dicSelectLEDdisp        : advance LED digit select (pulse)
//   ldMtens..ldSones, ld_num: per-digit load strobes and BCD load value
//   load_active, bad_key    : load-mode flag, rejected-byte pulse
// slave modport is the controller, master modport is its environment.
interface dicmd_ctrl_if;
    import dic_pkg::*;

    logic [BYTE_W-1:0]  rx_data;
    logic               rx_valid;
    logic               dicRun;
    logic               dicSelectLEDdisp;
    logic               ldMtens;
    logic               ldMones;
    logic               ldStens;
    logic               ldSones;
    logic [DIGIT_W-1:0] ld_num;
    logic               load_active;
    logic               bad_key;

    modport slave (
        input  rx_data, rx_valid,
        output dicRun, dicSelectLEDdisp, ldMtens, ldMones, ldStens, ldSones,
               ld_num, load_active, bad_key
    );

    modport master (
        output rx_data, rx_valid,
        input  dicRun, dicSelectLEDdisp, ldMtens, ldMones, ldStens, ldSones,
               ld_num, load_active, bad_key
    );

endinterface

// File: rtl/dicmd_digit_chk.sv
// Classifies a received byte as an ASCII decimal digit and range-checks it.
//   i_rx_data     : received byte
//   i_limit       : highest digit value accepted
//   o_is_digit_c  : byte is '0'..'9'
//   o_in_range_c  : byte is a digit no larger than i_limit
//   o_digit_c     : low nibble of the byte (digit value when o_is_digit_c)
module dicmd_digit_chk
    import dic_pkg::*;
(
    input  logic [BYTE_W-1:0]  i_rx_data,
    input  logic [DIGIT_W-1:0] i_limit,
    output logic               o_is_digit_c,
    output logic               o_in_range_c,
    output logic [DIGIT_W-1:0] o_digit_c
);

    assign o_is_digit_c = (i_rx_data >= ASCII_0) && (i_rx_data <= ASCII_9);
    assign o_digit_c    = i_rx_data[DIGIT_W-1:0];
    assign o_in_range_c = o_is_digit_c && (o_digit_c <= i_limit);

endmodule

// File: rtl/dicmd_ctrl.sv
// Command front end for the digital clock: decodes UART key bytes into
// run/freeze, LED select and a four-digit MMSS load sequence.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : dicmd_ctrl_if.slave (rx byte in, datapath controls out)
// All outputs are registered; each byte is answered the following cycle.
module dicmd_ctrl
    import dic_pkg::*;
#(
    parameter logic [BYTE_W-1:0] KEY_LOAD  = KEY_LOAD_DEF,
    parameter logic [BYTE_W-1:0] KEY_RUN   = KEY_RUN_DEF,
    parameter logic [BYTE_W-1:0] KEY_STOP  = KEY_STOP_DEF,
    parameter logic [BYTE_W-1:0] KEY_NEXT  = KEY_NEXT_DEF,
    parameter logic [BYTE_W-1:0] KEY_ABORT = KEY_ABORT_DEF
)
(
    input  logic          clk,
    input  logic          rst,
    dicmd_ctrl_if.slave   bus
);

    dic_state_t         r_state;
    dic_state_t         w_state_nxt;

    logic               r_run;
    logic               r_dic_run;
    logic               r_sel;
    logic               r_ld_mt;
    logic               r_ld_mo;
    logic               r_ld_st;
    logic               r_ld_so;
    logic [DIGIT_W-1:0] r_ld_num;
    logic               r_load_active;
    logic               r_bad_key;

    logic               w_run_nxt;
    logic               w_sel_nxt;
    logic               w_ld_mt_nxt;
    logic               w_ld_mo_nxt;
    logic               w_ld_st_nxt;
    logic               w_ld_so_nxt;
    logic [DIGIT_W-1:0] w_ld_num_nxt;
    logic               w_bad_key_nxt;

    logic [DIGIT_W-1:0] w_limit;
    logic               w_is_digit;
    logic               w_in_range;
    logic [DIGIT_W-1:0] w_digit;
    logic               w_abort;

    assign w_limit = digit_limit(r_state);

    dicmd_digit_chk u_digit_chk (
        .i_rx_data    (bus.rx_data),
        .i_limit      (w_limit),
        .o_is_digit_c (w_is_digit),
        .o_in_range_c (w_in_range),
        .o_digit_c    (w_digit)
    );

    // Abort only counts when the byte is not also being taken as a digit.
    assign w_abort = !w_is_digit && (bus.rx_data == KEY_ABORT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (bus.rx_valid) begin
            unique case (r_state)
                IDLE:    if (bus.rx_data == KEY_LOAD) w_state_nxt = LD_MT;
                LD_MT:   if (w_in_range) w_state_nxt = LD_MO;
                         else if (w_abort) w_state_nxt = IDLE;
                LD_MO:   if (w_in_range) w_state_nxt = LD_ST;
                         else if (w_abort) w_state_nxt = IDLE;
                LD_ST:   if (w_in_range) w_state_nxt = LD_SO;
                         else if (w_abort) w_state_nxt = IDLE;
                LD_SO:   if (w_in_range || w_abort) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Output decode (next values for the output registers)
    always_comb begin
        w_run_nxt     = r_run;
        w_sel_nxt     = 1'b0;
        w_ld_mt_nxt   = 1'b0;
        w_ld_mo_nxt   = 1'b0;
        w_ld_st_nxt   = 1'b0;
        w_ld_so_nxt   = 1'b0;
        w_ld_num_nxt  = r_ld_num;
        w_bad_key_nxt = 1'b0;
        if (bus.rx_valid) begin
            if (r_state == IDLE) begin
                if (bus.rx_data == KEY_RUN) begin
                    w_run_nxt = 1'b1;
                end else if (bus.rx_data == KEY_STOP) begin
                    w_run_nxt = 1'b0;
                end else if (bus.rx_data == KEY_NEXT) begin
                    w_sel_nxt = 1'b1;
                end else if (bus.rx_data != KEY_LOAD) begin
                    w_bad_key_nxt = 1'b1;
                end
            end else if (w_in_range) begin
                w_ld_num_nxt = w_digit;
                w_ld_mt_nxt  = (r_state == LD_MT);
                w_ld_mo_nxt  = (r_state == LD_MO);
                w_ld_st_nxt  = (r_state == LD_ST);
                w_ld_so_nxt  = (r_state == LD_SO);
            end else if (!w_abort) begin
                // Out-of-range digits and command keys are rejected in load mode.
                w_bad_key_nxt = 1'b1;
            end
        end
    end

    // Output registers; load_active and dicRun follow the next state so the
    // clock freezes the cycle after 'l' and resumes with the last digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run         <= 1'b0;
            r_dic_run     <= 1'b0;
            r_sel         <= 1'b0;
            r_ld_mt       <= 1'b0;
            r_ld_mo       <= 1'b0;
            r_ld_st       <= 1'b0;
            r_ld_so       <= 1'b0;
            r_ld_num      <= '0;
            r_load_active <= 1'b0;
            r_bad_key     <= 1'b0;
        end else begin
            r_run         <= w_run_nxt;
            r_dic_run     <= w_run_nxt && (w_state_nxt == IDLE);
            r_sel         <= w_sel_nxt;
            r_ld_mt       <= w_ld_mt_nxt;
            r_ld_mo       <= w_ld_mo_nxt;
            r_ld_st       <= w_ld_st_nxt;
            r_ld_so       <= w_ld_so_nxt;
            r_ld_num      <= w_ld_num_nxt;
            r_load_active <= (w_state_nxt != IDLE);
            r_bad_key     <= w_bad_key_nxt;
        end
    end

    assign bus.dicRun           = r_dic_run;
    assign bus.dicSelectLEDdisp = r_sel;
    assign bus.ldMtens          = r_ld_mt;
    assign bus.ldMones          = r_ld_mo;
    assign bus.ldStens          = r_ld_st;
    assign bus.ldSones          = r_ld_so;
    assign bus.ld_num           = r_ld_num;
    assign bus.load_active      = r_load_active;
    assign bus.bad_key          = r_bad_key;

endmodule

// File: tb/tb_dicmd_ctrl.sv
// Self-checking bench for dicmd_ctrl: directed scenarios followed by random
// key traffic, each cycle compared against a behavioural model.
module tb_dicmd_ctrl;

    localparam logic [7:0] K_L   = 8'h6C;
    localparam logic [7:0] K_R   = 8'h72;
    localparam logic [7:0] K_S   = 8'h73;
    localparam logic [7:0] K_N   = 8'h6E;
    localparam logic [7:0] K_ESC = 8'h1B;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dicmd_ctrl_if bus ();

    dicmd_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model state: which MMSS digit is expected next (-1 = not loading).
    int       m_pos;
    bit       m_run;
    bit [3:0] m_num;
    bit       m_sel;
    bit [3:0] m_strobe;   // {Mt, Mo, St, So}
    bit       m_bad;
    int       lim [4] = '{5, 9, 5, 9};

    function automatic logic [11:0] observed();
        return {bus.dicRun, bus.dicSelectLEDdisp, bus.ldMtens, bus.ldMones,
                bus.ldStens, bus.ldSones, bus.ld_num, bus.load_active, bus.bad_key};
    endfunction

    function automatic logic [11:0] expected();
        return {m_run && (m_pos < 0), m_sel, m_strobe, m_num, m_pos >= 0, m_bad};
    endfunction

    task automatic model_reset();
        m_pos = -1; m_run = 0; m_num = 0; m_sel = 0; m_strobe = 0; m_bad = 0;
    endtask

    task automatic model_step(input bit valid, input logic [7:0] b);
        m_sel = 0; m_strobe = 0; m_bad = 0;
        if (!valid) return;
        if (m_pos < 0) begin
            if (b == K_R)       m_run = 1;
            else if (b == K_S)  m_run = 0;
            else if (b == K_N)  m_sel = 1;
            else if (b == K_L)  m_pos = 0;
            else                m_bad = 1;
        end else if (b >= 8'h30 && b <= 8'h39 && int'(b - 8'h30) <= lim[m_pos]) begin
            m_strobe = 4'b1000 >> m_pos;
            m_num    = 4'(b - 8'h30);
            m_pos    = (m_pos == 3) ? -1 : m_pos + 1;
        end else if (b == K_ESC) begin
            m_pos = -1;
        end else begin
            m_bad = 1;
        end
    endtask

    task automatic check(input string tag);
        logic [11:0] obs, exp_v;
        obs   = observed();
        exp_v = expected();
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%03h expected=%03h (run,sel,Mt,Mo,St,So,num,act,bad)",
                   tag, cyc, obs, exp_v);
        end
    endtask

    // Present one byte (or an idle cycle) and check the registered response.
    task automatic step(input string tag, input bit valid, input logic [7:0] b);
        @(negedge clk);
        rst          = 1'b0;
        bus.rx_valid = valid;
        bus.rx_data  = valid ? b : 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        cyc++;
        model_step(valid, b);
        check(tag);
    endtask

    task automatic key(input string tag, input logic [7:0] b);
        step(tag, 1'b1, b);
    endtask

    // Reset for one cycle, optionally with a simultaneous byte that must be ignored.
    task automatic do_reset(input string tag, input bit valid, input logic [7:0] b);
        @(negedge clk);
        rst          = 1'b1;
        bus.rx_valid = valid;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        cyc++;
        model_reset();
        check(tag);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();

        // Reset state
        do_reset("reset", 1'b0, 8'h00);
        do_reset("reset_prio", 1'b1, K_R);
        step("idle_after_reset", 1'b0, 8'h00);

        // Run / stop
        key("run", K_R);
        step("run_hold", 1'b0, 8'h00);
        key("stop", K_S);

        // Full load sequence with run preserved
        key("run2", K_R);
        key("load", K_L);
        key("mt1", 8'h31);
        key("mo2", 8'h32);
        key("st3", 8'h33);
        key("so4", 8'h34);
        step("resume", 1'b0, 8'h00);

        // Out-of-range tens digit, then accepted
        key("load_b", K_L);
        key("mt7_bad", 8'h37);
        key("mt5", 8'h35);
        key("mo9", 8'h39);
        key("st6_bad", 8'h36);
        key("cmd_in_load", K_R);
        key("st0", 8'h30);
        key("so9", 8'h39);

        // Abort keeps earlier digits, then digits are bad in IDLE
        key("load_c", K_L);
        key("mt0", 8'h30);
        key("mo9b", 8'h39);
        key("esc", K_ESC);
        key("digit_idle", 8'h33);
        key("esc_idle", K_ESC);

        // Back-to-back LED select
        key("next1", K_N);
        key("next2", K_N);
        key("next3", K_N);
        step("next_idle", 1'b0, 8'h00);

        // Reset mid-load
        key("run3", K_R);
        key("load_d", K_L);
        key("mt1d", 8'h31);
        do_reset("mid_reset", 1'b0, 8'h00);
        key("after_reset", 8'h32);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int k;
            logic [7:0] b;
            k = $urandom_range(0, 19);
            if (k <= 9)       b = 8'(8'h30 + k);
            else if (k <= 11) b = K_L;
            else if (k == 12) b = K_R;
            else if (k == 13) b = K_S;
            else if (k == 14) b = K_N;
            else if (k == 15) b = K_ESC;
            else              b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 59) == 0)
                do_reset("rand_reset", $urandom_range(0, 1) == 1, b);
            else
                step("rand", $urandom_range(0, 3) != 0, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
